// File: rtl/sum_every_n_pkg.sv
// Shared types and helpers for the sum_every_n streaming reduction stage.
package sum_every_n_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // Number of bits needed to hold a count from 0 up to nMax inclusive.
    function automatic int cntWidth(input int nMax);
        return $clog2(nMax + 1);
    endfunction

    // Widens an iw-bit sample held in the low bits of x to 64 bits.
    // When signedMode is set, the sample's sign bit fills the upper bits.
    // Otherwise the upper bits are zero.
    function automatic logic [63:0] extendSample(input logic [63:0] x,
                                                 input int          iw,
                                                 input bit          signedMode);
        logic [63:0] r;
        logic        fill;
        fill = signedMode && x[iw-1];
        for (int b = 0; b < 64; b++) begin
            r[b] = (b < iw) ? x[b] : fill;
        end
        return r;
    endfunction

endpackage

// File: rtl/sum_every_n_lane.sv
// One lane of the reducer: an OW-bit accumulator that can load, add or clear.
// sum_o is the running total including this cycle's sample, so the top can
// capture a completed group in the same cycle as its last sample.
module sum_every_n_lane
    import sum_every_n_pkg::*;
#(
    parameter int IW     = 8,
    parameter int OW     = 12,
    parameter int SIGNED = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] sample_i,
    input  logic          load_i,
    input  logic          add_i,
    input  logic          clear_i,
    output logic [OW-1:0] sum_o
);

    logic [63:0]   extWide;
    logic [OW-1:0] sampleExt;
    logic          unusedExtBits;
    logic [OW-1:0] acc_q;
    logic [OW-1:0] acc_d;

    assign extWide       = extendSample(64'(sample_i), IW, SIGNED != 0);
    assign sampleExt     = extWide[OW-1:0];
    assign unusedExtBits = ^extWide[63:OW];

    // Running sum: a load starts a fresh group, an add extends the current one.
    // Clear wins so that an emitted group never leaks into the next one.
    always_comb begin
        sum_o = acc_q;
        if (load_i) begin
            sum_o = sampleExt;
        end else if (add_i) begin
            sum_o = acc_q + sampleExt;
        end
        acc_d = clear_i ? '0 : sum_o;
    end

    // Accumulator register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/sum_every_n.sv
// Streaming reducer: sums groups of up to N_MAX valid samples on CH lanes.
// It emits one registered sum per group, one cycle after the closing sample
// or after a flush.
module sum_every_n
    import sum_every_n_pkg::*;
#(
    parameter int IW     = 8,
    parameter int N_MAX  = 8,
    parameter int CH     = 1,
    parameter int SIGNED = 0,
    parameter int OW     = IW + cntWidth(N_MAX)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [cntWidth(N_MAX)-1:0]   i_len,
    input  logic                         i_dval,
    input  logic [CH*IW-1:0]             i,
    input  logic                         i_flush,
    output logic                         o_dval,
    output logic [CH*OW-1:0]             o,
    output logic [cntWidth(N_MAX)-1:0]   o_cnt
);

    localparam int            CW     = cntWidth(N_MAX);
    localparam logic [CW-1:0] NMAX_C = CW'(N_MAX);

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [CW-1:0]   len_q;
    logic [CW-1:0]   len_d;
    logic [CW-1:0]   effLen;
    logic [CW-1:0]   lenNow;
    logic [CW-1:0]   cntNew;
    logic            complete;
    logic            emit;
    logic            loadLane;
    logic            addLane;
    logic            clearLane;
    logic [CH*OW-1:0] laneSum;
    logic            oDval_q;
    logic [CH*OW-1:0] o_q;
    logic [CW-1:0]   oCnt_q;

    // A zero or out-of-range length means a full N_MAX group.
    assign effLen   = (i_len == '0 || i_len > NMAX_C) ? NMAX_C : i_len;
    assign lenNow   = (state_q == IDLE) ? effLen : len_q;
    assign cntNew   = !i_dval ? cnt_q : ((state_q == IDLE) ? CW'(1) : cnt_q + CW'(1));
    assign complete = i_dval && (cntNew == lenNow);

    // State, sample counter and latched group length.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    // An emit always returns to IDLE. Otherwise a valid sample opens or extends a group.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (emit) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (i_dval) begin
            state_d = ACC;
            cnt_d   = cntNew;
            if (state_q == IDLE) begin
                len_d = effLen;
            end
        end
    end

    // Emit and lane controls. A flush that coincides with completion still gives a single emit.
    always_comb begin
        emit      = complete || (i_flush && (i_dval || state_q == ACC));
        loadLane  = i_dval && (state_q == IDLE);
        addLane   = i_dval && (state_q == ACC);
        clearLane = emit;
    end

    for (genvar k = 0; k < CH; k++) begin : gLane
        sum_every_n_lane #(
            .IW     (IW),
            .OW     (OW),
            .SIGNED (SIGNED)
        ) uLane (
            .clk      (clk),
            .rst      (rst),
            .sample_i (i[k*IW +: IW]),
            .load_i   (loadLane),
            .add_i    (addLane),
            .clear_i  (clearLane),
            .sum_o    (laneSum[k*OW +: OW])
        );
    end

    // Output registers: o and o_cnt hold until the next emit, and o_dval is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            oDval_q <= 1'b0;
            o_q     <= '0;
            oCnt_q  <= '0;
        end else begin
            oDval_q <= emit;
            if (emit) begin
                o_q    <= laneSum;
                oCnt_q <= cntNew;
            end
        end
    end

    assign o_dval = oDval_q;
    assign o      = o_q;
    assign o_cnt  = oCnt_q;

endmodule

// File: tb/tb_sum_every_n.sv
// Directed bench for sum_every_n. It runs an unsigned single-lane instance
// and a signed two-lane instance side by side on shared control inputs.
module tb_sum_every_n;

    logic        clk;
    logic        rst;
    logic [3:0]  iLen;
    logic        iDval;
    logic        iFlush;
    logic [7:0]  iA;
    logic [15:0] iB;
    logic        oDvalA;
    logic [11:0] oA;
    logic [3:0]  oCntA;
    logic        oDvalB;
    logic [23:0] oB;
    logic [3:0]  oCntB;

    int testsRun;
    int testsFailed;

    sum_every_n #(.IW(8), .N_MAX(8), .CH(1), .SIGNED(0)) dutA (
        .clk     (clk),
        .rst     (rst),
        .i_len   (iLen),
        .i_dval  (iDval),
        .i       (iA),
        .i_flush (iFlush),
        .o_dval  (oDvalA),
        .o       (oA),
        .o_cnt   (oCntA)
    );

    sum_every_n #(.IW(8), .N_MAX(8), .CH(2), .SIGNED(1)) dutB (
        .clk     (clk),
        .rst     (rst),
        .i_len   (iLen),
        .i_dval  (iDval),
        .i       (iB),
        .i_flush (iFlush),
        .o_dval  (oDvalB),
        .o       (oB),
        .o_cnt   (oCntB)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and settle just after the clock edge that consumes them.
    task automatic applyStimulus(input logic dv, input logic fl,
                                 input logic [7:0] a, input logic [15:0] b);
        iDval  = dv;
        iFlush = fl;
        iA     = a;
        iB     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Directed sequence with hand-computed sums.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst    = 1'b0;
        iLen   = 4'd0;
        iDval  = 1'b0;
        iFlush = 1'b0;
        iA     = 8'd0;
        iB     = 16'd0;
        applyStimulus(0, 0, 8'd0, 16'd0);
        applyStimulus(0, 0, 8'd0, 16'd0);
        checkOutput("reset o_dval", 32'(oDvalA), 0);
        checkOutput("reset o", 32'(oA), 0);
        checkOutput("reset o_cnt", 32'(oCntA), 0);
        checkOutput("reset o lanes", 32'(oB), 0);

        // Length 3, samples 1..6: sums 6 then 15.
        rst  = 1'b1;
        iLen = 4'd3;
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1, 0, 8'(k), 16'd0);
            checkOutput("len3 o_dval", 32'(oDvalA), (k % 3 == 0) ? 1 : 0);
            checkOutput("len3 o", 32'(oA), (k < 3) ? 0 : ((k < 6) ? 6 : 15));
            checkOutput("len3 o_cnt", 32'(oCntA), (k < 3) ? 0 : 3);
        end

        // Length 4 of 255: no overflow, and a mid-group length change is ignored.
        iLen = 4'd4;
        applyStimulus(1, 0, 8'd255, 16'd0);
        iLen = 4'd2;
        applyStimulus(1, 0, 8'd255, 16'd0);
        checkOutput("len change ignored", 32'(oDvalA), 0);
        applyStimulus(1, 0, 8'd255, 16'd0);
        checkOutput("len4 third o_dval", 32'(oDvalA), 0);
        applyStimulus(1, 0, 8'd255, 16'd0);
        checkOutput("len4 o_dval", 32'(oDvalA), 1);
        checkOutput("len4 o", 32'(oA), 1020);
        checkOutput("len4 o_cnt", 32'(oCntA), 4);

        // Signed lanes: lane0 -3+1=-2, lane1 5+(-10)=-5.
        iLen = 4'd2;
        applyStimulus(1, 0, 8'd0, {8'd5, 8'hFD});
        checkOutput("signed first o_dval", 32'(oDvalB), 0);
        applyStimulus(1, 0, 8'd0, {8'hF6, 8'd1});
        checkOutput("signed o_dval", 32'(oDvalB), 1);
        checkOutput("signed lane0", 32'(oB[11:0]), 32'hFFE);
        checkOutput("signed lane1", 32'(oB[23:12]), 32'hFFB);
        checkOutput("signed o_cnt", 32'(oCntB), 2);

        // Back-to-back group: lanes (1,10),(2,20).
        applyStimulus(1, 0, 8'd0, {8'd10, 8'd1});
        checkOutput("lanes first o_dval", 32'(oDvalB), 0);
        applyStimulus(1, 0, 8'd0, {8'd20, 8'd2});
        checkOutput("lanes o_dval", 32'(oDvalB), 1);
        checkOutput("lanes lane0", 32'(oB[11:0]), 3);
        checkOutput("lanes lane1", 32'(oB[23:12]), 30);

        // i_len=0 means N_MAX: samples 1..8 sum to 36.
        iLen = 4'd0;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1, 0, 8'(k), 16'd0);
            checkOutput("len0 o_dval", 32'(oDvalA), (k == 8) ? 1 : 0);
        end
        checkOutput("len0 o", 32'(oA), 36);
        checkOutput("len0 o_cnt", 32'(oCntA), 8);

        // Flush a partial group, then flush in IDLE, then flush with a sample in IDLE.
        iLen = 4'd5;
        applyStimulus(1, 0, 8'd7, 16'd0);
        applyStimulus(1, 0, 8'd8, 16'd0);
        checkOutput("pre-flush o_dval", 32'(oDvalA), 0);
        applyStimulus(0, 1, 8'd0, 16'd0);
        checkOutput("flush o_dval", 32'(oDvalA), 1);
        checkOutput("flush o", 32'(oA), 15);
        checkOutput("flush o_cnt", 32'(oCntA), 2);
        applyStimulus(0, 1, 8'd0, 16'd0);
        checkOutput("idle flush o_dval", 32'(oDvalA), 0);
        checkOutput("idle flush o hold", 32'(oA), 15);
        applyStimulus(1, 1, 8'd9, 16'd0);
        checkOutput("flush+dval o_dval", 32'(oDvalA), 1);
        checkOutput("flush+dval o", 32'(oA), 9);
        checkOutput("flush+dval o_cnt", 32'(oCntA), 1);

        // Reset mid-group discards the partial sum.
        iLen = 4'd3;
        applyStimulus(1, 0, 8'd5, 16'd0);
        applyStimulus(1, 0, 8'd5, 16'd0);
        rst = 1'b0;
        applyStimulus(0, 0, 8'd0, 16'd0);
        rst = 1'b1;
        checkOutput("midreset o_dval", 32'(oDvalA), 0);
        checkOutput("midreset o", 32'(oA), 0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1, 0, 8'd1, 16'd0);
            checkOutput("post-reset o_dval", 32'(oDvalA), (k == 3) ? 1 : 0);
        end
        checkOutput("post-reset o", 32'(oA), 3);
        checkOutput("post-reset o_cnt", 32'(oCntA), 3);

        // Flush on the completing sample: one pulse only.
        applyStimulus(1, 0, 8'd2, 16'd0);
        applyStimulus(1, 0, 8'd3, 16'd0);
        applyStimulus(1, 1, 8'd4, 16'd0);
        checkOutput("complete+flush o_dval", 32'(oDvalA), 1);
        checkOutput("complete+flush o", 32'(oA), 9);
        checkOutput("complete+flush o_cnt", 32'(oCntA), 3);
        applyStimulus(0, 0, 8'd0, 16'd0);
        checkOutput("complete+flush single pulse", 32'(oDvalA), 0);

        // Length 1 emits on every sample.
        iLen = 4'd1;
        applyStimulus(1, 0, 8'd42, 16'd0);
        checkOutput("len1 o_dval", 32'(oDvalA), 1);
        checkOutput("len1 o", 32'(oA), 42);
        checkOutput("len1 o_cnt", 32'(oCntA), 1);
        applyStimulus(1, 0, 8'd43, 16'd0);
        checkOutput("len1 second o_dval", 32'(oDvalA), 1);
        checkOutput("len1 second o", 32'(oA), 43);
        applyStimulus(0, 0, 8'd0, 16'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
